shift_deserializer: RTL
=======================

// Module: shift_deserializer
// PURPOSE
//   Serial-to-parallel stage that collects TO bits from a 1-bit valid/ready stream into one word.
//   Sits directly downstream of shift_serializer and is its counterpart on the receive side.
//   A one-word output holding register lets the next word be shifted in while the previous word waits.
//   A bit or word is transferred on every cycle where both valid and ready are high.
// PARAMETERS
//   TO         100  word width in bits (>=2)
//   LOG2TO     8    bit-counter width; must satisfy 2**LOG2TO > TO
//   MSB_FIRST  1    1: first received bit lands in data_o[TO-1]; 0: first received bit lands in data_o[0]
// PORTS
//   clk        in   1       clock, all logic rising-edge
//   reset      in   1       synchronous reset, active-low (0 = reset)
//   data_i     in   1       serial data bit
//   valid_i    in   1       data_i is valid
//   ready_o    out  1       block accepts data_i this cycle
//   abort_i    in   1       discard the partially collected word
//   data_o     out  TO      parallel word
//   valid_o    out  1       data_o holds a complete word
//   ready_i    in   1       downstream consumes data_o this cycle
//   overrun_o  out  1       sticky flag: abort_i seen during a partial word; cleared only by reset
// BEHAVIOUR
// - Reset (reset==0 at a clk edge):
//   - State=COLLECT, counter=0, shift reg=0, data_o=0.
//   - valid_o=0, overrun_o=0; ready_o=0 while reset is low.
// - Serial acceptance: a bit is accepted when valid_i & ready_o.
//   - MSB_FIRST=1: shift {sr[TO-2:0],data_i}.
//   - MSB_FIRST=0: shift {data_i,sr[TO-1:1]}.
//   - Counter increments by 1 per accepted bit.
// - FSM states: COLLECT, FULL.
//   - COLLECT:
//     - ready_o=1.
//     - On accepting bit number TO (counter==TO-1), the word is complete and the counter returns to 0.
//     - If the output register is free this cycle (~valid_o | ready_i), the word goes to data_o at the same edge.
//       valid_o=1 in the next cycle; state stays COLLECT.
//     - Otherwise the word stays in the shift register and state goes to FULL.
//   - FULL:
//     - ready_o=0.
//     - When ready_i=1 (valid_o is necessarily 1), the shift reg moves to data_o and valid_o stays 1.
//     - State returns to COLLECT next cycle.
// - Latency: first bit accepted in cycle 0, last bit in cycle TO-1 -> valid_o=1 in cycle TO.
//   Back-to-back words with ready_i=1 give zero serial bubbles.
// - Output handshake:
//   - valid_o rises only on a word transfer.
//   - valid_o falls after a ready_i cycle when no new word arrives at that edge.
//   - data_o is stable while valid_o=1 & ready_i=0.
//   - data_o keeps its last value after consumption.
// - abort_i (COLLECT only):
//   - Counter reset to 0 and shift reg cleared; a bit presented in the same cycle is dropped, even if ready_o=1.
//   - If counter!=0, overrun_o sets.
//   - A word already in data_o is unaffected.
//   - abort_i in FULL is ignored.
// - Simultaneous events:
//   - Completing a word while ready_i consumes the old word: new word replaces it; valid_o stays 1.
//   - abort_i has priority over the TO-th bit.
// - reset low mid-word or in FULL: everything, including a pending data_o, is discarded as above.
// - Counter never exceeds TO-1; no wrap-around beyond TO.
// TESTING
// 1. TO=8, MSB_FIRST=1: send 1,0,1,0,0,1,0,1 with valid_i=1 and ready_i=1.
//    -> data_o=8'hA5, valid_o=1 exactly in cycle 8 for one cycle.
// 2. MSB_FIRST=0, same bits -> data_o=8'hA5 bit-reversed = 8'hA5 (palindrome).
//    Then send 8'h01's stream 0000_0001 -> data_o=8'h80.
// 3. Backpressure: ready_i=0, stream 16 bits (8'h3C then 8'hC3).
//    -> data_o=3C held; ready_o=0 after the 16th bit.
//    Raise ready_i -> data_o=C3 next cycle; ready_o=1 again.
// 4. Gapped input: valid_i toggled every cycle for 8'h5A.
//    -> word completes only after 8 accepted bits; no bits are counted on idle cycles.
// 5. abort_i after 3 bits, then 8 full bits of 8'hF0.
//    -> data_o=8'hF0 (no stale bits); overrun_o=1.
// 6. reset=0 after 5 bits and during FULL.
//    -> valid_o=0, overrun_o=0, ready_o=1 one cycle after reset=1.
//    -> next 8 bits decode correctly.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects TO bits from a 1-bit valid/ready stream into a word,
// with a one-word output holding register so the next word can shift in while the last one waits.
module shift_deserializer #(
    parameter int unsigned TO        = 100,
    parameter int unsigned LOG2TO    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          abort_i,
    output logic [TO-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overrun_o
);

    typedef enum logic {StCollect, StFull} state_e;

    localparam logic [LOG2TO-1:0] LastCnt = LOG2TO'(TO - 1);

    state_e            state_q, state_d;
    logic [LOG2TO-1:0] cnt_q, cnt_d;
    logic [TO-1:0]     sr_q, sr_d, sr_shift;
    logic [TO-1:0]     data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[TO-2:0], data_i};
        end else begin
            sr_shift = {data_i, sr_q[TO-1:1]};
        end
    end

    assign ready_o   = reset && (state_q == StCollect);
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StCollect: begin
                // Consumed word drops valid unless a new word lands at the same edge (below).
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                end
                if (abort_i) begin
                    cnt_d = '0;
                    sr_d  = '0;
                    if (cnt_q != '0) begin
                        overrun_d = 1'b1;
                    end
                end else if (valid_i) begin
                    sr_d = sr_shift;
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
                        if (!valid_q || ready_i) begin
                            data_d  = sr_shift;
                            valid_d = 1'b1;
                        end else begin
                            state_d = StFull;
                        end
                    end else begin
                        cnt_d = cnt_q + LOG2TO'(1);
                    end
                end
            end
            StFull: begin
                // valid_o is necessarily high here, so it simply stays high.
                if (ready_i) begin
                    data_d  = sr_q;
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StCollect;
            cnt_q     <= '0;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
